// File: rtl/qpu_event_queue.sv
// rtl/qpu_event_queue.sv - timestamped event FIFO with free-running timeline; fires head when timeline reaches it.
// Optional QPU_EVTQ_LATE_DROP_EN: late heads are popped silently instead of emitted.
module qpu_event_queue #(
  parameter int TIME_W = 32,
  parameter int DATA_W = 64,
  parameter int CH_NUM = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     exu_i_valid,
  output logic                     exu_i_ready,
  input  logic [TIME_W-1:0]        exu_i_time,
  input  logic [DATA_W-1:0]        exu_i_data,
  input  logic [CH_NUM-1:0]        exu_i_chmask,
  input  logic                     timer_i_ena,
  input  logic                     timer_i_clr,
  output logic [TIME_W-1:0]        timer_o_clk,
  output logic [CH_NUM-1:0]        evt_o_valid,
  output logic [DATA_W-1:0]        evt_o_data,
  output logic [$clog2(DEPTH):0]   evtq_o_count,
  output logic                     evtq_o_empty,
  output logic                     evtq_o_late
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]       PTR_ONE  = 1;
  localparam logic [AW:0]       FULL_CNT = DEPTH;
  localparam logic [TIME_W-1:0] TIME_ONE = 1;
  localparam logic [TIME_W-1:0] HALF     = TIME_ONE << (TIME_W - 1);

  logic [TIME_W-1:0] time_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [CH_NUM-1:0] mask_mem [DEPTH];

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [TIME_W-1:0] head_time;
  logic [DATA_W-1:0] head_data;
  logic [CH_NUM-1:0] head_mask;
  logic [TIME_W-1:0] head_diff;
  logic              head_reached;
  logic              head_late;
  logic              do_push;
  logic              do_pop;
  logic              do_emit;

  // Wrap bit in the pointers lets full and empty be told apart with no extra flag.
  assign evtq_o_count = wr_ptr - rd_ptr;
  assign evtq_o_empty = (wr_ptr == rd_ptr);
  assign exu_i_ready  = (evtq_o_count != FULL_CNT);

  assign head_time = time_mem[rd_ptr[AW-1:0]];
  assign head_data = data_mem[rd_ptr[AW-1:0]];
  assign head_mask = mask_mem[rd_ptr[AW-1:0]];

  // Half-range compare: the head is due once the timeline is at most half a wrap past it.
  assign head_diff    = timer_o_clk - head_time;
  assign head_reached = (head_diff < HALF);
  assign head_late    = (head_time != timer_o_clk);

  assign do_push = exu_i_valid && exu_i_ready && !timer_i_clr;
  assign do_pop  = !evtq_o_empty && head_reached && !timer_i_clr;

`ifdef QPU_EVTQ_LATE_DROP_EN
  assign do_emit = do_pop && !head_late;
`else
  assign do_emit = do_pop;
`endif

  always_ff @(posedge clk) begin
    if (do_push) begin
      time_mem[wr_ptr[AW-1:0]] <= exu_i_time;
      data_mem[wr_ptr[AW-1:0]] <= exu_i_data;
      mask_mem[wr_ptr[AW-1:0]] <= exu_i_chmask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_o_clk <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      evt_o_valid <= '0;
      evt_o_data  <= '0;
      evtq_o_late <= 1'b0;
    end else if (timer_i_clr) begin
      timer_o_clk <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      evt_o_valid <= '0;
      evtq_o_late <= 1'b0;
    end else begin
      if (timer_i_ena) begin
        timer_o_clk <= timer_o_clk + TIME_ONE;
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      evt_o_valid <= do_emit ? head_mask : '0;
      if (do_emit) begin
        evt_o_data <= head_data;
      end
      if (do_pop && head_late) begin
        evtq_o_late <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qpu_event_queue.sv
// tb/tb_qpu_event_queue.sv - directed plus random stimulus against a queue-based timeline model.
module tb_qpu_event_queue;

  localparam int TW    = 10;
  localparam int DEPTH = 8;

  typedef struct {
    logic [TW-1:0] t;
    logic [63:0]   d;
    logic [7:0]    m;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          exu_i_valid;
  logic          exu_i_ready;
  logic [TW-1:0] exu_i_time;
  logic [63:0]   exu_i_data;
  logic [7:0]    exu_i_chmask;
  logic          timer_i_ena;
  logic          timer_i_clr;
  logic [TW-1:0] timer_o_clk;
  logic [7:0]    evt_o_valid;
  logic [63:0]   evt_o_data;
  logic [3:0]    evtq_o_count;
  logic          evtq_o_empty;
  logic          evtq_o_late;

  int checks = 0;
  int errors = 0;
  int dut_fires;

  ent_t          q[$];
  logic [TW-1:0] m_timer;
  logic [7:0]    m_valid;
  logic [63:0]   m_data;
  logic          m_late;
  logic [TW-1:0] last_t;

  qpu_event_queue #(.TIME_W(TW), .DATA_W(64), .CH_NUM(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .exu_i_valid(exu_i_valid), .exu_i_ready(exu_i_ready),
    .exu_i_time(exu_i_time), .exu_i_data(exu_i_data), .exu_i_chmask(exu_i_chmask),
    .timer_i_ena(timer_i_ena), .timer_i_clr(timer_i_clr), .timer_o_clk(timer_o_clk),
    .evt_o_valid(evt_o_valid), .evt_o_data(evt_o_data),
    .evtq_o_count(evtq_o_count), .evtq_o_empty(evtq_o_empty), .evtq_o_late(evtq_o_late)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit due(input logic [TW-1:0] t, input logic [TW-1:0] now);
    logic [TW-1:0] d;
    d = now - t;
    return d < (1 << (TW - 1));
  endfunction

  task automatic model_reset();
    q.delete();
    m_timer = '0;
    m_valid = '0;
    m_data  = '0;
    m_late  = 1'b0;
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_timer"}, 128'(timer_o_clk), 128'(0));
    check({pfx, "_valid"}, 128'(evt_o_valid), 128'(0));
    check({pfx, "_data"},  128'(evt_o_data),  128'(0));
    check({pfx, "_count"}, 128'(evtq_o_count), 128'(0));
    check({pfx, "_empty"}, 128'(evtq_o_empty), 128'(1));
    check({pfx, "_late"},  128'(evtq_o_late), 128'(0));
    check({pfx, "_ready"}, 128'(exu_i_ready), 128'(1));
  endtask

  // One clock: drive inputs, advance the model by the queue rules, compare after the edge.
  task automatic step(input logic v, input logic [TW-1:0] t, input logic [63:0] d,
                      input logic [7:0] m, input logic ena, input logic clr);
    bit   accept, pop, late_now, emit;
    ent_t h, n;
    exu_i_valid  = v;
    exu_i_time   = t;
    exu_i_data   = d;
    exu_i_chmask = m;
    timer_i_ena  = ena;
    timer_i_clr  = clr;
    accept = v && (q.size() != DEPTH) && !clr;
    pop    = !clr && (q.size() > 0) && due(q[0].t, m_timer);
    n = '{t: t, d: d, m: m};
    @(posedge clk);
    if (clr) begin
      q.delete();
      m_timer = '0;
      m_valid = '0;
      m_late  = 1'b0;
    end else begin
      m_valid = '0;
      if (pop) begin
        h = q.pop_front();
        late_now = (h.t != m_timer);
        m_late   = m_late | late_now;
`ifdef QPU_EVTQ_LATE_DROP_EN
        emit = !late_now;
`else
        emit = 1'b1;
`endif
        if (emit) begin
          m_valid = h.m;
          m_data  = h.d;
        end
      end
      if (accept) q.push_back(n);
      if (ena) m_timer = m_timer + 1'b1;
    end
    #1;
    if (evt_o_valid != 0) dut_fires++;
    check("valid", 128'(evt_o_valid), 128'(m_valid));
    check("data",  128'(evt_o_data),  128'(m_data));
    check("count", 128'(evtq_o_count), 128'(q.size()));
    check("empty", 128'(evtq_o_empty), 128'(q.size() == 0));
    check("ready", 128'(exu_i_ready), 128'(q.size() != DEPTH));
    check("timer", 128'(timer_o_clk), 128'(m_timer));
    check("late",  128'(evtq_o_late), 128'(m_late));
  endtask

  task automatic idle(input int n, input logic ena);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, ena, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    exu_i_valid = 1'b0; exu_i_time = '0; exu_i_data = '0; exu_i_chmask = '0;
    timer_i_ena = 1'b0; timer_i_clr = 1'b0;
    model_reset();
    #12;
    check_reset_state("rst");
    rst_n = 1'b1;

    // On-time fire
    dut_fires = 0;
    step(1'b1, 10'd10, 64'hA5, 8'h01, 1'b1, 1'b0);
    idle(14, 1'b1);
    check("ontime_fires", 128'(dut_fires), 128'(1));
    check("ontime_late", 128'(evtq_o_late), 128'(0));

    // Full / back-pressure with the timeline stopped
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 10'(20 + 3 * i), 64'(32'hC000 + i), 8'(1 << i), 1'b0, 1'b0);
    check("full_count", 128'(evtq_o_count), 128'(8));
    check("full_ready", 128'(exu_i_ready), 128'(0));
    step(1'b1, 10'd50, 64'hDEAD, 8'hFF, 1'b0, 1'b0);
    check("ninth_ignored", 128'(evtq_o_count), 128'(8));
    dut_fires = 0;
    idle(60, 1'b1);
    check("full_fires", 128'(dut_fires), 128'(8));

    // Same timestamp twice
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    dut_fires = 0;
    step(1'b1, 10'd5, 64'h11, 8'h02, 1'b1, 1'b0);
    step(1'b1, 10'd5, 64'h22, 8'h04, 1'b1, 1'b0);
    idle(10, 1'b1);
`ifdef QPU_EVTQ_LATE_DROP_EN
    check("same_ts_fires", 128'(dut_fires), 128'(1));
`else
    check("same_ts_fires", 128'(dut_fires), 128'(2));
`endif
    check("same_ts_late", 128'(evtq_o_late), 128'(1));

    // Timeline wrap: push T=1 just before the wrap
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    idle((1 << TW) - 3, 1'b1);
    dut_fires = 0;
    step(1'b1, 10'd1, 64'h77, 8'h80, 1'b1, 1'b0);
    idle(2, 1'b1);
    check("wrap_no_early", 128'(dut_fires), 128'(0));
    idle(8, 1'b1);
    check("wrap_fires", 128'(dut_fires), 128'(1));
    check("wrap_late", 128'(evtq_o_late), 128'(0));

    // Clear mid-operation
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 10'(50 + 10 * i), 64'(i), 8'h10, 1'b1, 1'b0);
    idle(5, 1'b1);
    step(1'b1, 10'd60, 64'h99, 8'h01, 1'b1, 1'b1);
    check("clr_count", 128'(evtq_o_count), 128'(0));
    check("clr_timer", 128'(timer_o_clk), 128'(0));
    dut_fires = 0;
    idle(80, 1'b1);
    check("clr_no_fires", 128'(dut_fires), 128'(0));

    // Random traffic
    last_t = m_timer;
    for (int i = 0; i < 3000; i++) begin
      logic v, e, c;
      v = ($urandom_range(0, 9) < 4);
      e = ($urandom_range(0, 99) < 85);
      c = ($urandom_range(0, 249) == 0);
      if (q.size() == 0) last_t = m_timer + 10'($urandom_range(0, 10)) - 10'd2;
      else               last_t = last_t + 10'($urandom_range(0, 5));
      step(v, last_t, {$urandom, $urandom}, 8'($urandom_range(1, 255)), e, c);
      if (!(v && !c && q.size() > 0 && q[$].t == last_t)) last_t = (q.size() > 0) ? q[$].t : last_t;
    end

    // Asynchronous reset between edges with entries pending
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 10'(100 + i), 64'(i + 5), 8'h08, 1'b1, 1'b0);
    idle(2, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("arst");
    model_reset();
    #1 rst_n = 1'b1;
    idle(120, 1'b1);
    check("arst_no_fires", 128'(evtq_o_count), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qpu_event_queue.md
# qpu_event_queue

Timed-event queue directly downstream of the QPU execution unit's trigger interface. Buffers timestamped quantum events issued by the EXU, runs the free-running QPU timeline counter that the EXU reads back, and releases each event to the channel outputs when the timeline reaches its timestamp. It is the last sequential stage before the analog/MCU event wires.

## Interface

Parameters:
- TIME_W, 32: timestamp/timer width (matches QPU_TIME_WIDTH).
- DATA_W, 64: event payload width (matches QPU_EVENT_WIRE_WIDTH).
- CH_NUM, 8: number of event channels (matches QPU_EVENT_NUM).
- DEPTH, 8: queue entries; power of two, ≥2.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- exu_i_valid  in  1  push request from EXU.
- exu_i_ready  out  1  queue can accept a push.
- exu_i_time  in  TIME_W  absolute fire timestamp.
- exu_i_data  in  DATA_W  event payload.
- exu_i_chmask  in  CH_NUM  channels fired by this entry.
- timer_i_ena  in  1  timeline count enable.
- timer_i_clr  in  1  synchronous timeline clear plus queue flush.
- timer_o_clk  out  TIME_W  current timeline value, to EXU.
- evt_o_valid  out  CH_NUM  per-channel fire strobe, one cycle.
- evt_o_data  out  DATA_W  payload of the fired entry.
- evtq_o_count  out  $clog2(DEPTH)+1  occupancy.
- evtq_o_empty  out  1  count == 0.
- evtq_o_late  out  1  sticky late-event flag.

## Operation

- Storage: circular FIFO, DEPTH entries of {time, data, chmask}, write/read pointers with wrap bit.
- Push: exu_i_valid && exu_i_ready writes at the write pointer. exu_i_ready = (count != DEPTH); it depends only on registered count, so a pop in the same cycle does not raise ready when full.
- EXU issues non-decreasing timestamps; the queue never reorders.
- Timer: timer_o_clk increments by 1 each cycle timer_i_ena=1 and wraps modulo 2^TIME_W.
- Reached: head entry is reached when (timer_o_clk − head.time) mod 2^TIME_W has MSB = 0 (half-range wrap-safe compare).
- Pop: queue non-empty and head reached → pop head; the next cycle evt_o_valid = head.chmask, evt_o_data = head.data. Maximum of one pop per cycle.
- Late: a reached head whose time != timer_o_clk is late. A second entry with the same timestamp fires on the following cycle and is therefore late.
- Simultaneous push and pop: count unchanged, both pointers advance.
- timer_i_clr: next cycle timer=0, queue empty, evtq_o_late=0. Any push in that cycle is discarded. Clear takes priority over pop and ena.

## Timing

- Reset values: timer_o_clk=0, evt_o_valid=0, evt_o_data=0, evtq_o_count=0, evtq_o_empty=1, evtq_o_late=0, exu_i_ready=1.
- Push into an empty queue: entry becomes head at cycle N+1. Its earliest compare is at N+1, so its earliest fire strobe is at N+2. There is no bypass.
- On-time fire: timer equals T in cycle C, so evt_o_valid is asserted in cycle C+1 for exactly one cycle.
- evt_o_data holds its last value when evt_o_valid=0.
- Reset asserted mid-operation clears all state asynchronously. Queue contents are lost.

## Configuration

- QPU_EVTQ_LATE_DROP_EN defined: a late head is popped but not emitted. evt_o_valid stays 0 and evtq_o_late is set.
- Macro undefined: a late head is emitted normally and evtq_o_late is set.

## Test plan

- On-time fire: push {T=10, chmask=8'h01, data=64'hA5} with the timer at 0 and ena=1 → evt_o_valid=8'h01, evt_o_data=64'hA5 in the cycle after timer=10; late stays 0.
- Full/back-pressure: hold ena=0 and push 8 entries → count=8, exu_i_ready=0. A 9th push is ignored. Then enable the timer → 8 strobes in timestamp order and count returns to 0.
- Same timestamp: push T=5 twice → fires on consecutive cycles and evtq_o_late=1 after the second. With QPU_EVTQ_LATE_DROP_EN, only the first strobe appears.
- Wrap-around: preload the timer near 2^TIME_W−2 (run ena), then push T=1 → fires after the wrap, not immediately.
- Clear mid-operation: 3 entries pending, pulse timer_i_clr → next cycle count=0, timer=0, late=0, and no strobes follow.
- Async reset mid-operation: assert rst_n=0 between clock edges with entries pending → all outputs immediately take their reset values.
